// File: rtl/axis_ramp_generator.sv
// -----------------------------------------------------------------------------
// axis_ramp_generator
// AXI4-Stream master that emits a signed triangle or sawtooth ramp. The
// configuration is latched on start and held for the whole run. Optional
// block framing (tlast every 2^log_count beats) is enabled by defining the
// macro RG_TLAST_EN.
//
// Ports:
//   aclk           clock, rising edge
//   areset         synchronous active-high reset
//   RG_enable      start / keep generating (level)
//   RG_mode        0 = triangle, 1 = sawtooth
//   RG_step        unsigned increment per accepted beat
//   RG_limit       unsigned amplitude, output range [-limit, +limit]
//   RG_log_count   block length 2^RG_log_count beats (tlast spacing)
//   M_AXIS_tdata   signed sample
//   M_AXIS_tvalid  sample valid
//   M_AXIS_tready  downstream ready
//   M_AXIS_tlast   last beat of block (only with RG_TLAST_EN)
// -----------------------------------------------------------------------------
module axis_ramp_generator #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          RG_enable,
    input  logic                          RG_mode,
    input  logic [15:0]                   RG_step,
    input  logic [AXIS_TDATA_WIDTH-2:0]   RG_limit,
    input  logic [4:0]                    RG_log_count,
    output logic [AXIS_TDATA_WIDTH-1:0]   M_AXIS_tdata,
    output logic                          M_AXIS_tvalid,
    input  logic                          M_AXIS_tready
`ifdef RG_TLAST_EN
    ,
    output logic                          M_AXIS_tlast
`endif
);

    localparam int unsigned W  = AXIS_TDATA_WIDTH;
    localparam int unsigned XW = W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_mode;
    logic [15:0]         r_step;
    logic [W-2:0]        r_limit;
    logic signed [W-1:0] r_cur;
    logic                r_tvalid;
    logic                r_stop;

    logic                w_beat;
    logic                w_stop_now;
    logic                w_stop_ok;

    // Ramp arithmetic in W+1 signed bits; clamping keeps it in range.
    logic signed [XW-1:0] w_cur_x;
    logic signed [XW-1:0] w_step_x;
    logic signed [XW-1:0] w_lim_x;
    logic signed [XW-1:0] w_nlim_x;
    logic signed [XW-1:0] w_add;
    logic signed [XW-1:0] w_sub;
    logic signed [XW-1:0] w_up;
    logic signed [XW-1:0] w_dn;
    logic                 w_at_top;
    logic                 w_at_bot;
    logic signed [XW-1:0] w_next_x;
    state_t               w_next_state;

    assign w_beat     = r_tvalid & M_AXIS_tready;
    // Stop request seen this cycle counts immediately
    assign w_stop_now = r_stop | ~RG_enable;

    assign w_cur_x  = {r_cur[W-1], r_cur};
    assign w_step_x = {{(XW-16){1'b0}}, r_step};
    assign w_lim_x  = {2'b00, r_limit};
    assign w_nlim_x = -w_lim_x;
    assign w_add    = w_cur_x + w_step_x;
    assign w_sub    = w_cur_x - w_step_x;
    assign w_up     = (w_add > w_lim_x)  ? w_lim_x  : w_add;
    assign w_dn     = (w_sub < w_nlim_x) ? w_nlim_x : w_sub;
    assign w_at_top = (w_cur_x == w_lim_x);
    assign w_at_bot = (w_cur_x == w_nlim_x);

    // Next sample and direction, applied only on a beat
    always_comb begin
        w_next_state = r_state;
        w_next_x     = w_cur_x;
        case (r_state)
            ST_RISE: begin
                if (w_at_top) begin
                    if (r_mode) begin
                        w_next_x = w_nlim_x;
                    end else begin
                        w_next_state = ST_FALL;
                        w_next_x     = w_dn;
                    end
                end else begin
                    w_next_x = w_up;
                end
            end
            ST_FALL: begin
                if (w_at_bot) begin
                    w_next_state = ST_RISE;
                    w_next_x     = w_up;
                end else begin
                    w_next_x = w_dn;
                end
            end
            default: ;
        endcase
    end

`ifdef RG_TLAST_EN
    logic [4:0]  r_log;
    logic [31:0] r_cnt;
    logic        r_tlast;
    logic [31:0] w_mask;
    logic [31:0] w_cnt_next;

    assign w_mask     = (32'd1 << r_log) - 32'd1;
    assign w_cnt_next = (r_cnt == w_mask) ? 32'd0 : r_cnt + 32'd1;
    // Only stop on a block end so every emitted block is complete
    assign w_stop_ok  = w_beat & r_tlast;
    assign M_AXIS_tlast = r_tlast;
`else
    logic w_unused;

    assign w_unused  = ^RG_log_count;
    // With no beat outstanding there is nothing to finish
    assign w_stop_ok = w_beat | ~r_tvalid;
`endif

    // State machine with registered outputs
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state  <= ST_IDLE;
            r_mode   <= 1'b0;
            r_step   <= 16'd0;
            r_limit  <= '0;
            r_cur    <= '0;
            r_tvalid <= 1'b0;
            r_stop   <= 1'b0;
`ifdef RG_TLAST_EN
            r_log    <= 5'd0;
            r_cnt    <= 32'd0;
            r_tlast  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (RG_enable) begin
                        r_state  <= ST_RISE;
                        r_mode   <= RG_mode;
                        r_step   <= RG_step;
                        r_limit  <= RG_limit;
                        r_cur    <= '0;
                        r_tvalid <= 1'b1;
                        r_stop   <= 1'b0;
`ifdef RG_TLAST_EN
                        r_log    <= RG_log_count;
                        r_cnt    <= 32'd0;
                        r_tlast  <= (RG_log_count == 5'd0);
`endif
                    end
                end
                default: begin
                    if (!RG_enable) begin
                        r_stop <= 1'b1;
                    end
                    if (w_stop_now && w_stop_ok) begin
                        r_state  <= ST_IDLE;
                        r_cur    <= '0;
                        r_tvalid <= 1'b0;
                        r_stop   <= 1'b0;
`ifdef RG_TLAST_EN
                        r_cnt    <= 32'd0;
                        r_tlast  <= 1'b0;
`endif
                    end else if (w_beat) begin
                        r_state <= w_next_state;
                        r_cur   <= W'(w_next_x);
`ifdef RG_TLAST_EN
                        r_cnt   <= w_cnt_next;
                        r_tlast <= (w_cnt_next == w_mask);
`endif
                    end
                end
            endcase
        end
    end

    assign M_AXIS_tdata  = r_cur;
    assign M_AXIS_tvalid = r_tvalid;

endmodule

// File: tb/tb_axis_ramp_generator.sv
module tb_axis_ramp_generator;

    logic        clk;
    logic        areset;
    logic        enable;
    logic        mode;
    logic [15:0] step;
    logic [30:0] limit;
    logic [4:0]  log_count;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    int n_tests;
    int n_fail;
    int exp_q[$];

    axis_ramp_generator #(.AXIS_TDATA_WIDTH(32)) dut (
        .aclk          (clk),
        .areset        (areset),
        .RG_enable     (enable),
        .RG_mode       (mode),
        .RG_step       (step),
        .RG_limit      (limit),
        .RG_log_count  (log_count),
        .M_AXIS_tdata  (tdata),
        .M_AXIS_tvalid (tvalid),
        .M_AXIS_tready (tready)
`ifdef RG_TLAST_EN
        ,
        .M_AXIS_tlast  (tlast)
`endif
    );

`ifndef RG_TLAST_EN
    assign tlast = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Called on a negedge; returns on a negedge with the DUT idle
    task automatic do_reset();
        areset = 1'b1;
        enable = 1'b0;
        tready = 1'b1;
        repeat (2) @(negedge clk);
        areset = 1'b0;
    endtask

    // Raise enable; returns on the negedge where beat 0 is presented
    task automatic start(input logic m, input int s, input int lim, input int lg);
        mode      = m;
        step      = 16'(s);
        limit     = 31'(lim);
        log_count = 5'(lg);
        enable    = 1'b1;
        tready    = 1'b1;
        @(negedge clk);
    endtask

    // Check exp_q beat by beat with tready high; tlast every 'period' beats
    task automatic run_seq(input string tag, input int period);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_valid[%0d]", tag, i), 32'(tvalid), 32'd1);
            check($sformatf("%s_data[%0d]", tag, i), tdata, 32'(exp_q[i]));
`ifdef RG_TLAST_EN
            check($sformatf("%s_last[%0d]", tag, i), 32'(tlast),
                  32'((i % period) == (period - 1)));
`endif
            @(negedge clk);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        areset    = 1'b1;
        enable    = 1'b0;
        mode      = 1'b0;
        step      = 16'd0;
        limit     = 31'd0;
        log_count = 5'd0;
        tready    = 1'b1;
        @(negedge clk);
        do_reset();

        check("rst_valid", 32'(tvalid), 32'd0);
        check("rst_data", tdata, 32'd0);
        check("rst_last", 32'(tlast), 32'd0);

        // Triangle
        start(1'b0, 10, 30, 5);
        exp_q = {0, 10, 20, 30, 20, 10, 0, -10, -20, -30, -20, -10, 0};
        run_seq("tri", 32);
        do_reset();

        // Clamp at the limits
        start(1'b0, 20, 30, 5);
        exp_q = {0, 20, 30, 10, -10, -30, -10, 10, 30, 10};
        run_seq("clamp", 32);
        do_reset();

        // Sawtooth
        start(1'b1, 10, 20, 5);
        exp_q = {0, 10, 20, -20, -10, 0, 10, 20, -20};
        run_seq("saw", 32);
        do_reset();

        // step = 0 and limit = 0 hold zero
        start(1'b0, 0, 30, 5);
        exp_q = {0, 0, 0, 0};
        run_seq("step0", 32);
        do_reset();
        start(1'b0, 10, 0, 5);
        exp_q = {0, 0, 0, 0};
        run_seq("lim0", 32);
        do_reset();

        // Backpressure on the value 30
        start(1'b0, 10, 30, 5);
        exp_q = {0, 10, 20};
        run_seq("bp_pre", 32);
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold_valid[%0d]", i), 32'(tvalid), 32'd1);
            check($sformatf("bp_hold_data[%0d]", i), tdata, 32'd30);
        end
        tready = 1'b1;
        exp_q = {30, 20, 10};
        run_seq("bp_post", 32);
        do_reset();

        // Blocks of 4 and stop after beat 5
        start(1'b0, 10, 30, 2);
        exp_q = {0, 10, 20, 30, 20, 10};
        run_seq("blk", 4);
        check("blk_b6_data", tdata, 32'd0);
        check("blk_b6_last", 32'(tlast), 32'd0);
        enable = 1'b0;
        @(negedge clk);
`ifdef RG_TLAST_EN
        check("blk_b7_valid", 32'(tvalid), 32'd1);
        check("blk_b7_data", tdata, 32'hFFFF_FFF6);
        check("blk_b7_last", 32'(tlast), 32'd1);
        @(negedge clk);
`endif
        check("stop_valid", 32'(tvalid), 32'd0);
        check("stop_data", tdata, 32'd0);
        @(negedge clk);
        check("stop_hold_valid", 32'(tvalid), 32'd0);
        do_reset();

        // Reset while a beat is stalled, then restart
        start(1'b0, 10, 30, 2);
        exp_q = {0, 10};
        run_seq("mr_pre", 4);
        tready = 1'b0;
        @(negedge clk);
        check("mr_stall_data", tdata, 32'd20);
        areset = 1'b1;
        @(negedge clk);
        check("mr_rst_valid", 32'(tvalid), 32'd0);
        check("mr_rst_data", tdata, 32'd0);
        check("mr_rst_last", 32'(tlast), 32'd0);
        areset = 1'b0;
        tready = 1'b1;
        @(negedge clk);
        exp_q = {0, 10, 20, 30, 20};
        run_seq("mr_post", 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
